// File: rtl/csel_sync_nway_if.sv
// Handshake bundle between an upstream controller and csel_sync_nway.
// Signal names are seen from the selector's side.
interface csel_sync_nway_if #(
  parameter int N_CH = 3
);
  logic            i_drive;
  logic            o_free;
  logic            o_fire;
  logic            o_busy;
  logic            o_timeout;
  logic [N_CH-1:0] i_valid;
  logic [N_CH-1:0] o_driveNext;
  logic [N_CH-1:0] i_freeNext;

  modport slave (
    input  i_drive, i_valid, i_freeNext,
    output o_free, o_fire, o_busy, o_driveNext, o_timeout
  );

  modport master (
    output i_drive, i_valid, i_freeNext,
    input  o_free, o_fire, o_busy, o_driveNext, o_timeout
  );
endinterface

// File: rtl/csel_sync_nway.sv
// Clocked N-way click selector: accept, settle delay, drive selected channels, await free.
// Optional WAIT watchdog enabled by defining CSEL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for i_drive
// DELAY   | datapath settle countdown
// DRIVE   | o_driveNext pulse cycle, free sampling starts
// WAIT    | collecting free pulses from selected channels
// DONE    | o_free pulse cycle
module csel_sync_nway #(
  parameter int N_CH      = 3,
  parameter int DELAY     = 4,
  parameter int MULTICAST = 1,
  parameter int WAIT_ALL  = 0,
  parameter int TIMEOUT   = 256
) (
  input logic               clk,
  input logic               rst,
  csel_sync_nway_if.slave   bus
);
  localparam int CW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((DELAY > 0) ? DELAY - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_DRIVE, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_state;
  logic [N_CH-1:0] r_sel, w_sel;
  logic [N_CH-1:0] r_got, w_got;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_fire, w_fire;
  logic            r_free, w_free;
  logic            r_busy, w_busy;
  logic [N_CH-1:0] r_drv, w_drv;

  logic [N_CH-1:0] w_sel_in;
  logic [N_CH-1:0] w_hit;
  logic            w_done;

  // x & -x isolates the lowest set bit for single-cast selection
  assign w_sel_in = (MULTICAST != 0) ? bus.i_valid
                                     : (bus.i_valid & (~bus.i_valid + N_CH'(1)));
  assign w_hit    = bus.i_freeNext & r_sel;
  assign w_done   = (WAIT_ALL != 0) ? ((r_got | w_hit) == r_sel) : (|w_hit);

`ifdef CSEL_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_tmo, w_tmo;
`endif

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_got   = r_got;
    w_cnt   = r_cnt;
    w_fire  = 1'b0;
    w_free  = 1'b0;
    w_drv   = '0;
`ifdef CSEL_TIMEOUT_EN
    w_tmo   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.i_drive) begin
          w_sel  = w_sel_in;
          w_got  = '0;
          w_fire = 1'b1;
          // An empty selection passes through DRIVE with a zero mask so
          // o_free still lands one cycle after o_fire.
          if ((w_sel_in == '0) || (DELAY == 0)) begin
            w_state = S_DRIVE;
            w_drv   = w_sel_in;
          end else begin
            w_state = S_DELAY;
            w_cnt   = CNT_LOAD;
          end
        end
      end
      S_DELAY: begin
        if (r_cnt == '0) begin
          w_state = S_DRIVE;
          w_drv   = r_sel;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_DRIVE: begin
        w_got = r_got | w_hit;
        if ((r_sel == '0) || w_done) begin
          w_state = S_DONE;
          w_free  = 1'b1;
        end else begin
          w_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_got = r_got | w_hit;
        if (w_done) begin
          w_state = S_DONE;
          w_free  = 1'b1;
        end
`ifdef CSEL_TIMEOUT_EN
        else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_state = S_DONE;
          w_free  = 1'b1;
          w_tmo   = 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_got   = '0;
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_got   <= '0;
      r_cnt   <= '0;
      r_fire  <= 1'b0;
      r_free  <= 1'b0;
      r_busy  <= 1'b0;
      r_drv   <= '0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_got   <= w_got;
      r_cnt   <= w_cnt;
      r_fire  <= w_fire;
      r_free  <= w_free;
      r_busy  <= w_busy;
      r_drv   <= w_drv;
    end
  end

`ifdef CSEL_TIMEOUT_EN
  // Watchdog counts WAIT cycles only; it restarts on every WAIT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_tcnt <= (r_state == S_WAIT) ? (r_tcnt + TW'(1)) : '0;
      r_tmo  <= w_tmo;
    end
  end
  assign bus.o_timeout = r_tmo;
`else
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_fire      = r_fire;
  assign bus.o_free      = r_free;
  assign bus.o_busy      = r_busy;
  assign bus.o_driveNext = r_drv;
endmodule
